usb_annunciator_sched: RTL and testbench
========================================

USB_ANNUNCIATOR_SCHED -- requirements
Module: usb_annunciator_sched

Interface
REQ-001 Parameters (name, default, meaning): ROM_AW, 10, status-ROM address width.
REQ-002 FIFO_DEPTH, 4, event FIFO entries; power of two.
REQ-003 BANNER_RESTART, 4, ROM address where repeat banners start, skipping the leading erase-screen bytes.
REQ-004 Ports (name, direction, width, meaning): clk48  in  1  sole clock; reset is synchronous and active-high.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 rom_addr  out  ROM_AW  status-ROM address; rom_data is valid one cycle after rom_addr.
REQ-007 rom_data  in  8  status-ROM byte; 0x00 terminates the banner.
REQ-008 banner_req  in  1  single-cycle pulse requesting a banner replay.
REQ-009 usb_rst, transaction_active, direction_in, setup, success  in  1 each  USB core status.
REQ-010 endpoint  in  4  endpoint of the current transaction.
REQ-011 tx_valid  out  1, tx_data  out  8, tx_ready  in  1  byte stream to the UART; transfer occurs when tx_valid&&tx_ready.

Function
REQ-012 Event capture: a falling edge of transaction_active pushes {setup, direction_in, endpoint, success}; a rising edge of usb_rst pushes a reset event; edges are detected against registered previous values.
REQ-013 At most one push per cycle; when both edges occur in the same cycle, the reset event is pushed and the transaction event is dropped.
REQ-014 FIFO full with no pop that cycle: the push is dropped; full with a pop in the same cycle: the push succeeds.
REQ-015 Event record = 4 bytes: type ('S' setup, 'I' IN, 'O' OUT, 'R' reset), uppercase hex endpoint ('-' for reset), '+'/'-' for success ('-' for reset), 0x0A.
REQ-016 States: IDLE, BAN_ADDR, BAN_WAIT, BAN_OUT, EVT_OUT.
REQ-017 A banner is pending after reset, starting at address 0; banner_req sets pending with start address BANNER_RESTART; a request during an active banner is ignored.
REQ-018 Arbitration is evaluated in IDLE only: a non-empty FIFO goes to EVT_OUT; otherwise a pending banner goes to BAN_ADDR; otherwise stay in IDLE.
REQ-019 Records and banners are never interleaved; a started banner runs to its terminator.
REQ-020 BAN_ADDR drives rom_addr; BAN_WAIT waits one cycle; in BAN_OUT, rom_data 0x00 clears pending, emits nothing and returns to IDLE; any other byte is presented until accepted, then the address increments and the FSM returns to BAN_ADDR.
REQ-021 rom_addr wraps modulo 2^ROM_AW; an unterminated ROM loops and does not hang the FSM.
REQ-022 tx_data and tx_valid are registered and held stable while tx_valid&&!tx_ready.
REQ-023 EVT_OUT pops the FIFO when the 4th byte is accepted, then returns to IDLE.
REQ-024 Throughput: with tx_ready held at 1, an event record is 4 consecutive bytes; each banner byte takes 3 cycles.

Reset
REQ-025 On rst: tx_valid=0, tx_data=0x00, rom_addr=0, FSM=IDLE, FIFO empty, edge registers=0, banner pending from address 0.
REQ-026 rst mid-record or mid-banner abandons it; tx_valid is 0 in the cycle after rst is sampled.

Configuration
REQ-027 Macro USB_ANN_OVERFLOW_REPORT_EN.
- Defined: an 8-bit saturating counter counts dropped pushes. When nonzero and the FSM is in IDLE with the FIFO empty, it emits record '!', hex high nibble, hex low nibble, 0x0A, then clears. Drops during that record are kept.
- Undefined: drops are silent and the counter is absent.

Structure
REQ-028 Package usb_ann_pkg holds the state enum, the event struct, record character constants and a nibble-to-ASCII function.
REQ-029 Sub-module usb_ann_evt_fifo: synchronous FIFO with push/pop/full/empty, registered-pointer design, one-entry-ahead data output.

Verification
REQ-030 Reset, ROM "\014AB\0", tx_ready=1 -> bytes 0x0C,0x41,0x42, then tx_valid=0.
REQ-031 banner_req after the first banner, ROM "\014\033[HOK\0" with OK at address 4 -> only 'O','K' sent.
REQ-032 Setup transaction on endpoint 3 with success=1 -> 'S','3','+',0x0A; IN on endpoint 0xA with success=0 -> 'I','A','-',0x0A.
REQ-033 tx_ready=0 for 10 cycles mid-record -> tx_data and tx_valid stable; the record completes unaltered afterwards.
REQ-034 6 events while tx_ready=0, FIFO_DEPTH=4 -> 4 records emitted; with the macro defined, '!','0','2',0x0A follows.
REQ-035 usb_rst rise coincident with transaction end -> one 'R','-','-',0x0A record only; rst asserted mid-banner -> banner restarts at address 0.

Source files
------------

// File: rtl/usb_ann_pkg.sv
// usb_ann_pkg: shared types and character helpers for the USB status annunciator.
package usb_ann_pkg;

    typedef enum logic [2:0] {
        IDLE,
        BAN_ADDR,
        BAN_WAIT,
        BAN_OUT,
        EVT_OUT
    } state_t;

    // One captured USB event; is_reset overrides the transaction fields.
    typedef struct packed {
        logic       is_reset;
        logic       setup;
        logic       dir_in;
        logic [3:0] ep;
        logic       success;
    } usb_evt_t;

    localparam logic [7:0] CH_SETUP = 8'h53;  // 'S'
    localparam logic [7:0] CH_IN    = 8'h49;  // 'I'
    localparam logic [7:0] CH_OUT   = 8'h4F;  // 'O'
    localparam logic [7:0] CH_RESET = 8'h52;  // 'R'
    localparam logic [7:0] CH_PLUS  = 8'h2B;  // '+'
    localparam logic [7:0] CH_MINUS = 8'h2D;  // '-'
    localparam logic [7:0] CH_BANG  = 8'h21;  // '!'
    localparam logic [7:0] CH_LF    = 8'h0A;

    // Uppercase ASCII hex digit for a nibble.
    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    // Byte i of the 4-byte record describing event e.
    function automatic logic [7:0] evt_char(input usb_evt_t e, input logic [1:0] i);
        logic [7:0] c;
        case (i)
            2'd0:    c = e.is_reset ? CH_RESET : e.setup ? CH_SETUP : e.dir_in ? CH_IN : CH_OUT;
            2'd1:    c = e.is_reset ? CH_MINUS : hex_char(e.ep);
            2'd2:    c = (e.is_reset || !e.success) ? CH_MINUS : CH_PLUS;
            default: c = CH_LF;
        endcase
        return c;
    endfunction

    // Byte i of the overflow record for drop count cnt.
    function automatic logic [7:0] ovf_char(input logic [7:0] cnt, input logic [1:0] i);
        logic [7:0] c;
        case (i)
            2'd0:    c = CH_BANG;
            2'd1:    c = hex_char(cnt[7:4]);
            2'd2:    c = hex_char(cnt[3:0]);
            default: c = CH_LF;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/usb_ann_evt_fifo.sv
// usb_ann_evt_fifo: synchronous event FIFO, registered pointers with wrap bit,
// head entry presented combinationally so the consumer sees it before popping.
module usb_ann_evt_fifo
    import usb_ann_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     push,
    input  usb_evt_t push_data,
    input  logic     pop,
    output usb_evt_t head,
    output logic     full,
    output logic     empty
);

    localparam int AW = $clog2(DEPTH);

    usb_evt_t    mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_push;
    logic        do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr[AW-1:0]];

    // Pointer update.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write; contents need no reset since pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/usb_annunciator_sched.sv
// usb_annunciator_sched: captures USB core events into a small FIFO and
// serialises them as 4-byte ASCII records to a UART byte stream, interleaved
// (never mixed) with a NUL-terminated banner read from a status ROM.
// Optional macro USB_ANN_OVERFLOW_REPORT_EN adds a saturating drop counter
// reported as a '!hh' record.
module usb_annunciator_sched
    import usb_ann_pkg::*;
#(
    parameter int ROM_AW         = 10,
    parameter int FIFO_DEPTH     = 4,
    parameter int BANNER_RESTART = 4
) (
    input  logic              clk48,
    input  logic              rst,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    input  logic              banner_req,
    input  logic              usb_rst,
    input  logic              transaction_active,
    input  logic              direction_in,
    input  logic              setup,
    input  logic              success,
    input  logic [3:0]        endpoint,
    output logic              tx_valid,
    output logic [7:0]        tx_data,
    input  logic              tx_ready
);

    state_t     state;
    logic [1:0] idx;
    logic [1:0] nidx;
    logic       pending;
    logic       prev_ta;
    logic       prev_usb_rst;
    logic       ta_fall;
    logic       rst_rise;
    logic       push;
    logic       pop;
    logic       rec_last;
    logic       full;
    logic       empty;
    usb_evt_t   push_evt;
    usb_evt_t   head;
    logic [7:0] next_char;

    // Edge detectors for the USB status lines.
    always_ff @(posedge clk48) begin
        if (rst) begin
            prev_ta      <= 1'b0;
            prev_usb_rst <= 1'b0;
        end else begin
            prev_ta      <= transaction_active;
            prev_usb_rst <= usb_rst;
        end
    end

    assign ta_fall  = prev_ta && !transaction_active;
    assign rst_rise = usb_rst && !prev_usb_rst;
    assign push     = ta_fall || rst_rise;

    // A bus reset wins over a coincident transaction end.
    always_comb begin
        push_evt = '0;
        if (rst_rise) begin
            push_evt.is_reset = 1'b1;
        end else begin
            push_evt.setup   = setup;
            push_evt.dir_in  = direction_in;
            push_evt.ep      = endpoint;
            push_evt.success = success;
        end
    end

    usb_ann_evt_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk48),
        .rst      (rst),
        .push     (push),
        .push_data(push_evt),
        .pop      (pop),
        .head     (head),
        .full     (full),
        .empty    (empty)
    );

    assign rec_last = (state == EVT_OUT) && tx_ready && (idx == 2'd3);
    assign nidx     = idx + 2'd1;

`ifdef USB_ANN_OVERFLOW_REPORT_EN
    logic [7:0] drop_cnt;
    logic [7:0] ovf_snap;
    logic       ovf_rec;
    logic       drop;
    logic       ovf_start;

    assign pop       = rec_last && !ovf_rec;
    assign drop      = push && full && !pop;
    assign ovf_start = (state == IDLE) && empty && (drop_cnt != 8'd0);

    // Saturating drop counter; cleared as its report starts so later drops are kept.
    always_ff @(posedge clk48) begin
        if (rst) begin
            drop_cnt <= 8'd0;
        end else if (ovf_start) begin
            drop_cnt <= drop ? 8'd1 : 8'd0;
        end else if (drop && drop_cnt != 8'hFF) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end

    // Next record byte, from the FIFO head or the overflow snapshot.
    always_comb begin
        next_char = evt_char(head, nidx);
        if (ovf_rec) next_char = ovf_char(ovf_snap, nidx);
    end
`else
    assign pop = rec_last;

    // Next record byte from the FIFO head.
    always_comb begin
        next_char = evt_char(head, nidx);
    end
`endif

    // Output scheduler: arbitrates in IDLE, then runs a record or banner to completion.
    always_ff @(posedge clk48) begin
        if (rst) begin
            state    <= IDLE;
            tx_valid <= 1'b0;
            tx_data  <= 8'h00;
            rom_addr <= '0;
            pending  <= 1'b1;
            idx      <= 2'd0;
`ifdef USB_ANN_OVERFLOW_REPORT_EN
            ovf_rec  <= 1'b0;
            ovf_snap <= 8'd0;
`endif
        end else begin
            // Pending is only clear outside banner states, so this never fights the pointer increment.
            if (banner_req && !pending) begin
                pending  <= 1'b1;
                rom_addr <= ROM_AW'(BANNER_RESTART);
            end
            case (state)
                IDLE: begin
                    idx <= 2'd0;
                    if (!empty) begin
                        tx_data  <= evt_char(head, 2'd0);
                        tx_valid <= 1'b1;
                        state    <= EVT_OUT;
`ifdef USB_ANN_OVERFLOW_REPORT_EN
                        ovf_rec  <= 1'b0;
                    end else if (ovf_start) begin
                        ovf_snap <= drop_cnt;
                        ovf_rec  <= 1'b1;
                        tx_data  <= CH_BANG;
                        tx_valid <= 1'b1;
                        state    <= EVT_OUT;
`endif
                    end else if (pending) begin
                        state <= BAN_ADDR;
                    end
                end
                BAN_ADDR: begin
                    state <= BAN_WAIT;
                end
                BAN_WAIT: begin
                    // ROM byte is valid now; load it so it is on the wire in BAN_OUT.
                    if (rom_data != 8'h00) begin
                        tx_data  <= rom_data;
                        tx_valid <= 1'b1;
                    end
                    state <= BAN_OUT;
                end
                BAN_OUT: begin
                    // No byte was loaded only when the ROM returned the terminator.
                    if (!tx_valid) begin
                        pending <= 1'b0;
                        state   <= IDLE;
                    end else if (tx_ready) begin
                        tx_valid <= 1'b0;
                        rom_addr <= rom_addr + ROM_AW'(1);
                        state    <= BAN_ADDR;
                    end
                end
                EVT_OUT: begin
                    if (tx_ready) begin
                        if (idx == 2'd3) begin
                            tx_valid <= 1'b0;
                            state    <= IDLE;
                        end else begin
                            tx_data <= next_char;
                            idx     <= nidx;
                        end
                    end
                end
                default: begin
                    tx_valid <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_usb_annunciator_sched.sv
// tb_usb_annunciator_sched: directed stimulus with a byte scoreboard; the
// monitor checks every accepted UART byte and output hold during stalls.
module tb_usb_annunciator_sched;

    logic       clk48 = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] rom_addr;
    logic [7:0] rom_data = 8'h00;
    logic       banner_req = 1'b0;
    logic       usb_rst = 1'b0;
    logic       transaction_active = 1'b0;
    logic       direction_in = 1'b0;
    logic       setup = 1'b0;
    logic       success = 1'b0;
    logic [3:0] endpoint = 4'h0;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready = 1'b1;

    logic [7:0] rom [1024];
    logic [7:0] expq [$];
    int         total = 0;
    int         bad = 0;

    always #5 clk48 = ~clk48;

    // Synchronous ROM: data valid one cycle after the address.
    always @(posedge clk48) rom_data <= rom[rom_addr];

    usb_annunciator_sched dut (
        .clk48             (clk48),
        .rst               (rst),
        .rom_addr          (rom_addr),
        .rom_data          (rom_data),
        .banner_req        (banner_req),
        .usb_rst           (usb_rst),
        .transaction_active(transaction_active),
        .direction_in      (direction_in),
        .setup             (setup),
        .success           (success),
        .endpoint          (endpoint),
        .tx_valid          (tx_valid),
        .tx_data           (tx_data),
        .tx_ready          (tx_ready)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, got, exp);
        end
    endtask

    task automatic exp_bytes(input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input logic [7:0] b3, input int n);
        if (n > 0) expq.push_back(b0);
        if (n > 1) expq.push_back(b1);
        if (n > 2) expq.push_back(b2);
        if (n > 3) expq.push_back(b3);
    endtask

    task automatic wait_drain(input string name, input int maxc);
        for (int i = 0; i < maxc && expq.size() != 0; i++) @(posedge clk48);
        total++;
        if (expq.size() != 0) begin
            bad++;
            $display("FAIL %s: %0d bytes still expected, want 0", name, expq.size());
            expq.delete();
        end
        repeat (4) @(posedge clk48);
        #1;
    endtask

    task automatic do_txn(input logic s, input logic din, input logic [3:0] ep, input logic ok);
        setup = s; direction_in = din; endpoint = ep; success = ok;
        transaction_active = 1'b1;
        @(posedge clk48); #1;
        transaction_active = 1'b0;
        @(posedge clk48); #1;
        setup = 1'b0; direction_in = 1'b0; endpoint = 4'h0; success = 1'b0;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 1024; i++) rom[i] = 8'h00;
    endtask

    // Monitor: scoreboard compare on each transfer, plus hold check after a stalled cycle.
    initial begin : monitor
        logic       pv;
        logic [7:0] pd;
        logic [7:0] e;
        pv = 1'b0;
        pd = 8'h00;
        forever begin
            @(negedge clk48);
            if (rst) begin
                pv = 1'b0;
            end else begin
                if (pv) begin
                    chk("hold_valid", {31'd0, tx_valid}, 32'd1);
                    chk("hold_data", {24'd0, tx_data}, {24'd0, pd});
                end
                if (tx_valid && tx_ready) begin
                    if (expq.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL extra_byte: got %02h want none", tx_data);
                    end else begin
                        e = expq.pop_front();
                        chk("tx_byte", {24'd0, tx_data}, {24'd0, e});
                    end
                end
                pv = tx_valid && !tx_ready;
                pd = tx_data;
            end
        end
    end

    initial begin
        // Reset state and power-on banner "\014AB\0".
        clear_rom();
        rom[0] = 8'h0C; rom[1] = 8'h41; rom[2] = 8'h42;
        rst = 1'b1;
        repeat (3) @(posedge clk48);
        @(negedge clk48);
        chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
        chk("rst_rom_addr", {22'd0, rom_addr}, 32'd0);
        exp_bytes(8'h0C, 8'h41, 8'h42, 8'h00, 3);
        @(posedge clk48); #1;
        rst = 1'b0;
        wait_drain("banner0", 200);
        chk("idle_after_banner", {31'd0, tx_valid}, 32'd0);

        // Replay banner from BANNER_RESTART with "\014\033[HOK\0".
        clear_rom();
        rom[0] = 8'h0C; rom[1] = 8'h1B; rom[2] = 8'h5B; rom[3] = 8'h48;
        rom[4] = 8'h4F; rom[5] = 8'h4B;
        exp_bytes(8'h4F, 8'h4B, 8'h00, 8'h00, 2);
        banner_req = 1'b1;
        @(posedge clk48); #1;
        banner_req = 1'b0;
        wait_drain("banner_restart", 200);

        // Setup ep3 success, then IN ep A fail.
        exp_bytes("S", "3", "+", 8'h0A, 4);
        do_txn(1'b1, 1'b0, 4'h3, 1'b1);
        exp_bytes("I", "A", "-", 8'h0A, 4);
        do_txn(1'b0, 1'b1, 4'hA, 1'b0);
        wait_drain("records", 200);

        // Stall mid-record for 10 cycles.
        exp_bytes("O", "5", "+", 8'h0A, 4);
        do_txn(1'b0, 1'b0, 4'h5, 1'b1);
        for (int i = 0; i < 50 && expq.size() > 2; i++) begin
            @(posedge clk48); #1;
        end
        tx_ready = 1'b0;
        repeat (10) @(posedge clk48);
        #1;
        tx_ready = 1'b1;
        wait_drain("stall_record", 200);

        // Six events while stalled: four fit, two are dropped.
        tx_ready = 1'b0;
        do_txn(1'b1, 1'b0, 4'h1, 1'b1);
        do_txn(1'b0, 1'b0, 4'h2, 1'b0);
        do_txn(1'b0, 1'b1, 4'hF, 1'b1);
        do_txn(1'b0, 1'b0, 4'h4, 1'b1);
        do_txn(1'b0, 1'b1, 4'h6, 1'b1);
        do_txn(1'b1, 1'b0, 4'h7, 1'b0);
        exp_bytes("S", "1", "+", 8'h0A, 4);
        exp_bytes("O", "2", "-", 8'h0A, 4);
        exp_bytes("I", "F", "+", 8'h0A, 4);
        exp_bytes("O", "4", "+", 8'h0A, 4);
`ifdef USB_ANN_OVERFLOW_REPORT_EN
        exp_bytes("!", "0", "2", 8'h0A, 4);
`endif
        repeat (3) @(posedge clk48);
        #1;
        tx_ready = 1'b1;
        wait_drain("overflow", 400);

        // Bus reset coincident with transaction end: reset record only.
        setup = 1'b1; endpoint = 4'h9; success = 1'b1;
        transaction_active = 1'b1;
        @(posedge clk48); #1;
        transaction_active = 1'b0;
        usb_rst = 1'b1;
        exp_bytes("R", "-", "-", 8'h0A, 4);
        @(posedge clk48); #1;
        setup = 1'b0; endpoint = 4'h0; success = 1'b0;
        repeat (3) @(posedge clk48);
        #1;
        usb_rst = 1'b0;
        wait_drain("usb_reset", 200);

        // Reset during a stalled banner: output drops, banner replays from 0.
        tx_ready = 1'b0;
        banner_req = 1'b1;
        @(posedge clk48); #1;
        banner_req = 1'b0;
        repeat (6) @(posedge clk48);
        #1;
        chk("stalled_banner_valid", {31'd0, tx_valid}, 32'd1);
        chk("stalled_banner_data", {24'd0, tx_data}, 32'h4F);
        rst = 1'b1;
        @(posedge clk48);
        @(negedge clk48);
        chk("midrst_tx_valid", {31'd0, tx_valid}, 32'd0);
        chk("midrst_rom_addr", {22'd0, rom_addr}, 32'd0);
        exp_bytes(8'h0C, 8'h1B, 8'h5B, 8'h48, 4);
        exp_bytes(8'h4F, 8'h4B, 8'h00, 8'h00, 2);
        @(posedge clk48); #1;
        rst = 1'b0;
        tx_ready = 1'b1;
        wait_drain("banner_after_rst", 300);
        chk("final_idle", {31'd0, tx_valid}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
